// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with write-back bypass and a per-register
// pending-write scoreboard (busy flags plus an incrementally maintained pending count).
module regfile_sb #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wb_en_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic [NREGS-1:0]    busy_vec_o,
  output logic [AW:0]         pend_cnt_o
);

  localparam bit HAS_R0 = (ZERO_R0 != 0);
  localparam bit HAS_BP = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [AW-1:0]    rd_a [NRD];
  logic             wr_ok, iss_ok, cnt_inc, cnt_dec;

  assign wr_ok  = wb_en_i  && !(HAS_R0 && (wb_addr_i  == '0));
  assign iss_ok = iss_en_i && !(HAS_R0 && (iss_addr_i == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NREGS; n++) regs_q[n] <= '0;
    end else if (wr_ok) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NREGS; n++) begin
      if (HAS_R0 && (n == 0))                              busy_d[n] = 1'b0;
      else if (flush_i)                                     busy_d[n] = 1'b0;
      else if (iss_en_i && (iss_addr_i == AW'(n)))          busy_d[n] = 1'b1;
      else if (wb_en_i && (wb_addr_i == AW'(n)))            busy_d[n] = 1'b0;
    end
  end

  // Count tracks only real flag transitions, so re-issue and same-register
  // issue+WB leave it untouched.
  always_comb begin
    cnt_inc = iss_ok && !flush_i && !busy_q[iss_addr_i];
    cnt_dec = wr_ok && !flush_i && busy_q[wb_addr_i] &&
              !(iss_en_i && (iss_addr_i == wb_addr_i));
    if (flush_i) cnt_d = '0;
    else         cnt_d = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign pend_cnt_o = cnt_q;

  // Read priority: reset, hardwired r0, write-back bypass, then stored state.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_a[p] = rd_addr_i[p*AW +: AW];
      rd_data_o[p*XLEN +: XLEN] = regs_q[rd_a[p]];
      rd_busy_o[p]              = busy_q[rd_a[p]];
      if (HAS_BP && wb_en_i && (wb_addr_i == rd_a[p])) begin
        rd_data_o[p*XLEN +: XLEN] = wb_data_i;
        rd_busy_o[p] = iss_en_i && (iss_addr_i == rd_a[p]) && !flush_i;
      end
      if ((HAS_R0 && (rd_a[p] == '0)) || !rst_n) begin
        rd_data_o[p*XLEN +: XLEN] = '0;
        rd_busy_o[p]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default parameters): expected values are queued as
// stimulus is applied and popped when the matching DUT output is sampled.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]     rd_data;
  logic [1:0]      rd_busy;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [31:0]     wb_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            flush;
  logic [31:0]     busy_vec;
  logic [AW:0]     pend_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush),
    .busy_vec_o(busy_vec), .pend_cnt_o(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic idle();
    wb_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = {5'd5, 5'd5};
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE_F00D;
    iss_en = 1'b1; iss_addr = 5'd5; flush = 1'b0;
    #12;
    push(32'h0); chk("rst_rd0", rd_data[31:0]);
    push(32'h0); chk("rst_rd1", rd_data[63:32]);
    push(32'h0); chk("rst_busy", {30'd0, rd_busy});
    push(32'h0); chk("rst_vec", busy_vec);
    push(32'h0); chk("rst_cnt", {26'd0, pend_cnt});
    idle();
    @(negedge clk); rst_n = 1'b1;
    step();

    // bypass of x5 write
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; #1;
    push(32'hDEAD_BEEF); chk("byp_x5", rd_data[31:0]);
    push(32'hDEAD_BEEF); chk("byp_x5_p1", rd_data[63:32]);
    step(); idle(); #1;
    push(32'hDEAD_BEEF); chk("stored_x5", rd_data[31:0]);

    // r0 hardwired
    rd_addr = {5'd0, 5'd0};
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    iss_en = 1'b1; iss_addr = 5'd0; #1;
    push(32'h0); chk("r0_byp_p0", rd_data[31:0]);
    push(32'h0); chk("r0_byp_p1", rd_data[63:32]);
    step(); idle(); #1;
    push(32'h0); chk("r0_stored", rd_data[31:0]);
    push(32'h0); chk("r0_notbusy", busy_vec);

    // issue then write-back x7
    rd_addr = {5'd5, 5'd7};
    iss_en = 1'b1; iss_addr = 5'd7;
    step(); idle(); #1;
    push(32'h0000_0080); chk("x7_vec", busy_vec);
    push(32'd1);         chk("x7_cnt", {26'd0, pend_cnt});
    push(32'd1);         chk("x7_rdbusy", {31'd0, rd_busy[0]});
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55; #1;
    push(32'h55); chk("x7_byp", rd_data[31:0]);
    push(32'd0);  chk("x7_byp_busy", {31'd0, rd_busy[0]});
    step(); idle(); #1;
    push(32'h0);  chk("x7_vec_clr", busy_vec);
    push(32'd0);  chk("x7_cnt_clr", {26'd0, pend_cnt});
    push(32'h55); chk("x7_stored", rd_data[31:0]);

    // issue beats same-cycle write-back on x3
    rd_addr = {5'd9, 5'd3};
    iss_en = 1'b1; iss_addr = 5'd3;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA; #1;
    push(32'hAA); chk("x3_byp", rd_data[31:0]);
    push(32'd1);  chk("x3_byp_busy", {31'd0, rd_busy[0]});
    step(); idle(); #1;
    push(32'h0000_0008); chk("x3_vec", busy_vec);
    push(32'd1);         chk("x3_cnt", {26'd0, pend_cnt});
    push(32'hAA);        chk("x3_stored", rd_data[31:0]);
    iss_en = 1'b1; iss_addr = 5'd9;
    step(); idle(); #1;
    push(32'd2); chk("x9_cnt", {26'd0, pend_cnt});
    push(32'd1); chk("x9_rdbusy", {31'd0, rd_busy[1]});
    iss_en = 1'b1; iss_addr = 5'd4;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    step(); idle(); #1;
    push(32'd2);         chk("swap_cnt", {26'd0, pend_cnt});
    push(32'h0000_0018); chk("swap_vec", busy_vec);
    push(32'h99);        chk("x9_stored", rd_data[63:32]);
    iss_en = 1'b1; iss_addr = 5'd3;
    step(); idle(); #1;
    push(32'd2);         chk("reiss_cnt", {26'd0, pend_cnt});
    push(32'h0000_0018); chk("reiss_vec", busy_vec);

    // flush, refill, flush with issue
    flush = 1'b1;
    step(); idle(); #1;
    push(32'd0); chk("flush1_cnt", {26'd0, pend_cnt});
    for (int r = 1; r <= 3; r++) begin
      iss_en = 1'b1; iss_addr = AW'(r);
      step();
    end
    idle(); #1;
    push(32'd3);         chk("fill_cnt", {26'd0, pend_cnt});
    push(32'h0000_000E); chk("fill_vec", busy_vec);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
    step(); idle(); #1;
    push(32'h0); chk("flush2_vec", busy_vec);
    push(32'd0); chk("flush2_cnt", {26'd0, pend_cnt});

    // reset in the middle of a write
    iss_en = 1'b1; iss_addr = 5'd6;
    step();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h7777_7777;
    #2 rst_n = 1'b0;
    #1;
    push(32'h0); chk("midrst_rd", rd_data[31:0]);
    push(32'h0); chk("midrst_vec", busy_vec);
    @(negedge clk); idle(); rst_n = 1'b1;
    rd_addr = {5'd3, 5'd5}; #1;
    push(32'h0); chk("post_rst_x5", rd_data[31:0]);
    push(32'h0); chk("post_rst_x3", rd_data[63:32]);
    push(32'd0); chk("post_rst_cnt", {26'd0, pend_cnt});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
